multdiv_ctrl: RTL

//  Sequencer for the HI/LO mult/div resource in EX. Accepts one decoded mult/div/HI-LO op, runs the

---
 rtl/decode_pkg.sv | 63 ++++++
 rtl/div_iter.sv | 82 ++++++++
 rtl/multdiv_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared mult/div decode types, FSM states and op classifiers.
// MULTDIV_ACC_EN: when defined, MADD/MADDU/MSUB/MSUBU are sequenced ops.
package decode_pkg;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        OP_NOP   = 7'd0,
        OP_MULT  = 7'd1,
        OP_MULTU = 7'd2,
        OP_DIV   = 7'd3,
        OP_DIVU  = 7'd4,
        OP_MADD  = 7'd5,
        OP_MADDU = 7'd6,
        OP_MSUB  = 7'd7,
        OP_MSUBU = 7'd8,
        OP_MTHI  = 7'd9,
        OP_MTLO  = 7'd10,
        OP_ADD   = 7'd16
    } decoded_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ACC  = 3'd2,
        DIV  = 3'd3,
        FIX  = 3'd4
    } md_state_t;

    function automatic logic is_md_multicycle(input decoded_op_t op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MULTDIV_ACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_md_op(input decoded_op_t op);
        return is_md_multicycle(op) || op == OP_MTHI || op == OP_MTLO;
    endfunction

    function automatic logic is_div_op(input decoded_op_t op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic is_signed_op(input decoded_op_t op);
        return op == OP_MULT || op == OP_DIV || op == OP_MADD || op == OP_MSUB;
    endfunction

    function automatic logic is_acc_op(input decoded_op_t op);
        return op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU;
    endfunction

    function automatic logic is_sub_op(input decoded_op_t op);
        return op == OP_MSUB || op == OP_MSUBU;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring unsigned divider core, DIV_STEPS quotient bits per step.
// Divide by zero naturally yields quot=all ones, rem=dividend.
module div_iter
    import decode_pkg::*;
#(
    parameter int DIV_STEPS = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o,
    output logic            last_o
);

    localparam int N  = XLEN / DIV_STEPS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   sh;
    logic [XLEN-1:0] q, r;

    // One step: DIV_STEPS shift/trial-subtract iterations
    always_comb begin
        q  = quot_q;
        r  = rem_q;
        sh = '0;
        for (int i = 0; i < DIV_STEPS; i++) begin
            sh = {r, q[XLEN-1]};
            q  = {q[XLEN-2:0], 1'b0};
            if (sh >= {1'b0, dvs_q}) begin
                sh   = sh - {1'b0, dvs_q};
                q[0] = 1'b1;
            end
            r = sh[XLEN-1:0];
        end
    end

    // Load operands on start, advance on step
    always_comb begin
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (start_i) begin
            cnt_d  = '0;
            quot_d = a_i;
            rem_d  = '0;
            dvs_d  = b_i;
        end else if (step_i) begin
            cnt_d  = cnt_q + CW'(1);
            quot_d = q;
            rem_d  = r;
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign last_o = step_i && (cnt_q == CW'(N - 1));
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// HI/LO mult/div sequencer for EX: FSM, sign handling, HI/LO ownership.
// MULTDIV_ACC_EN: builds the ACC state for MADD[U]/MSUB[U].
module multdiv_ctrl
    import decode_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DIV_STEPS = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid_i,
    input  decoded_op_t     op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    md_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    decoded_op_t op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;

    logic        sgn_i, sgn_q;
    logic [31:0] amag, bmag;
    logic        div_start, div_step, div_last;
    logic [31:0] div_quot, div_rem;
    logic [63:0] opa, opb, prod;
    logic        done_c;
`ifdef MULTDIV_ACC_EN
    logic [63:0] hilo, acc_res;
`endif

    // Operand magnitudes for the divider, taken at issue
    always_comb begin
        sgn_i = is_signed_op(op_i);
        amag  = (sgn_i && a_i[31]) ? 32'd0 - a_i : a_i;
        bmag  = (sgn_i && b_i[31]) ? 32'd0 - b_i : b_i;
    end

    // Full 64-bit product of latched operands, sign-extended for signed ops
    always_comb begin
        sgn_q = is_signed_op(op_q);
        opa   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        opb   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = opa * opb;
    end

`ifdef MULTDIV_ACC_EN
    // Accumulator add/sub, wraps mod 2^64
    always_comb begin
        hilo    = {hi_q, lo_q};
        acc_res = is_sub_op(op_q) ? hilo - prod : hilo + prod;
    end
`endif

    div_iter #(
        .DIV_STEPS(DIV_STEPS)
    ) u_div (
        .clk    (clk),
        .resetn (resetn),
        .start_i(div_start),
        .step_i (div_step),
        .a_i    (amag),
        .b_i    (bmag),
        .quot_o (div_quot),
        .rem_o  (div_rem),
        .last_o (div_last)
    );

    // Sequencer next-state and HI/LO update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        div_start = 1'b0;
        div_step  = 1'b0;
        done_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i && is_md_op(op_i)) begin
                    if (op_i == OP_MTHI) begin
                        hi_d = a_i;
                    end else if (op_i == OP_MTLO) begin
                        lo_d = a_i;
                    end else begin
                        op_d = op_i;
                        a_d  = a_i;
                        b_d  = b_i;
                        if (is_div_op(op_i)) begin
                            state_d   = DIV;
                            div_start = 1'b1;
                            qneg_d    = sgn_i && (a_i[31] ^ b_i[31]);
                            rneg_d    = sgn_i && a_i[31];
                        end else begin
                            state_d = MUL;
                            cnt_d   = CW'(MUL_LAT - 1);
                        end
                    end
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
`ifdef MULTDIV_ACC_EN
                    if (is_acc_op(op_q)) begin
                        state_d = ACC;
                    end else begin
                        {hi_d, lo_d} = prod;
                        done_c       = 1'b1;
                        state_d      = IDLE;
                    end
`else
                    {hi_d, lo_d} = prod;
                    done_c       = 1'b1;
                    state_d      = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef MULTDIV_ACC_EN
            ACC: begin
                {hi_d, lo_d} = acc_res;
                done_c       = 1'b1;
                state_d      = IDLE;
            end
`endif
            DIV: begin
                div_step = 1'b1;
                if (div_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = qneg_q ? 32'd0 - div_quot : div_quot;
                hi_d    = rneg_q ? 32'd0 - div_rem : div_rem;
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush_i) begin
            state_d   = IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            div_start = 1'b0;
        end
    end

    // State and architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign done_o  = done_c && !flush_i;
    assign stall_o = !flush_i &&
                     ((state_q == IDLE && valid_i && is_md_multicycle(op_i)) ||
                      (state_q != IDLE && !done_c));
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
